// File: rtl/axi_vlctx_control_mq.sv
// AXI4-lite controlled transmit queue for the VLC OFDM chain: software fills staging words,
// committed symbols are streamed out as AXI4-stream packets tagged with their modulation type.
module axi_vlctx_control_mq #(
    parameter int unsigned C_DATA_WORDS = 8,
    parameter int unsigned C_SYM_DEPTH  = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic [1:0]  mod_type,
    output logic [7:0]  guard_interval,
    output logic [15:0] ifft_config,
    output logic        ifft_config_en,
    input  logic        done_tick,
    output logic        irq
);

    localparam int unsigned PtrW = (C_SYM_DEPTH > 1) ? $clog2(C_SYM_DEPTH) : 1;
    localparam int unsigned IdxW = $clog2(C_DATA_WORDS);

    typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;
    typedef enum logic {StIdle, StSend} st_state_e;

    wr_state_e        wr_state_q;
    logic [6:0]       awaddr_q;
    logic             awready_q, wready_q, bvalid_q;

    rd_state_e        rd_state_q;
    logic             arready_q, rvalid_q;
    logic [31:0]      rdata_q, rd_data_d;

    logic [10:0]      ctrl_q;
    logic             ovf_q, done_flag_q;
    logic [15:0]      done_cnt_q;
    logic [4:0]       cnt_q, cnt_d;
    logic [15:0]      outst_q, outst_d;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [IdxW-1:0]  word_idx_q;
    st_state_e        st_q;
    logic             tvalid_q;

    logic [31:0]      slot_q [C_SYM_DEPTH][C_DATA_WORDS];
    logic [1:0]       tag_q  [C_SYM_DEPTH];

    // Index of the final word of a symbol: wps - 1 with wps = 1 << mod.
    function automatic logic [IdxW-1:0] last_idx(input logic [1:0] m);
        return IdxW'((5'd1 << m) - 5'd1);
    endfunction

    logic            wr_fire, aw_stage, stage_wr, drop, store, commit;
    logic            ctrl_wr, stat_wr, dcnt_wr;
    logic [IdxW-1:0] aw_idx, ar_idx;
    logic            ar_stage;
    logic            full, empty, busy, last_beat, pop;
    logic [31:0]     status;
    logic            unused_addr;

    assign unused_addr = ^{s_axi_awaddr[31:7], s_axi_araddr[31:7]};

    always_comb begin
        wr_fire  = wready_q & s_axi_wvalid;
        aw_idx   = awaddr_q[IdxW+1:2];
        aw_stage = awaddr_q[6] & ({1'b0, awaddr_q[5:2]} < 5'(C_DATA_WORDS));
        full     = (cnt_q == 5'(C_SYM_DEPTH));
        empty    = (cnt_q == 5'd0);
        stage_wr = wr_fire & aw_stage;
        drop     = stage_wr & full;
        store    = stage_wr & ~full;
        commit   = store & (aw_idx == last_idx(ctrl_q[1:0]));
        ctrl_wr  = wr_fire & (awaddr_q == 7'h00);
        stat_wr  = wr_fire & (awaddr_q == 7'h04);
        dcnt_wr  = wr_fire & (awaddr_q == 7'h08);
        last_beat = (word_idx_q == last_idx(tag_q[rd_ptr_q]));
        pop      = (st_q == StSend) & m_axis_tready & last_beat;
        busy     = (cnt_q != 5'd0) | (st_q == StSend) | (outst_q != 16'd0);
        status   = {22'b0, done_flag_q, ovf_q, cnt_q, empty, full, busy};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (commit && !pop) begin
            cnt_d = cnt_q + 5'd1;
        end else if (pop && !commit) begin
            cnt_d = cnt_q - 5'd1;
        end
        // A commit and a done_tick in the same cycle cancel out.
        outst_d = outst_q;
        if (commit && !done_tick) begin
            outst_d = outst_q + 16'd1;
        end else if (!commit && done_tick && outst_q != 16'd0) begin
            outst_d = outst_q - 16'd1;
        end
    end

    always_comb begin
        ar_idx    = s_axi_araddr[IdxW+1:2];
        ar_stage  = s_axi_araddr[6] & ({1'b0, s_axi_araddr[5:2]} < 5'(C_DATA_WORDS));
        rd_data_d = '0;
        case (s_axi_araddr[6:0])
            7'h00:   rd_data_d = {21'b0, ctrl_q};
            7'h04:   rd_data_d = status;
            7'h08:   rd_data_d = {16'b0, done_cnt_q};
            default: if (ar_stage) rd_data_d = slot_q[wr_ptr_q][ar_idx];
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= WrIdle;
            awaddr_q   <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            unique case (wr_state_q)
                WrIdle: if (s_axi_awvalid) begin
                    awaddr_q   <= s_axi_awaddr[6:0];
                    awready_q  <= 1'b0;
                    wready_q   <= 1'b1;
                    wr_state_q <= WrData;
                end
                WrData: if (s_axi_wvalid) begin
                    wready_q   <= 1'b0;
                    bvalid_q   <= 1'b1;
                    wr_state_q <= WrResp;
                end
                WrResp: if (s_axi_bready) begin
                    bvalid_q   <= 1'b0;
                    awready_q  <= 1'b1;
                    wr_state_q <= WrIdle;
                end
                default: begin
                    awready_q  <= 1'b1;
                    wready_q   <= 1'b0;
                    bvalid_q   <= 1'b0;
                    wr_state_q <= WrIdle;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            unique case (rd_state_q)
                RdIdle: if (s_axi_arvalid) begin
                    rdata_q    <= rd_data_d;
                    arready_q  <= 1'b0;
                    rvalid_q   <= 1'b1;
                    rd_state_q <= RdData;
                end
                RdData: if (s_axi_rready) begin
                    rvalid_q   <= 1'b0;
                    arready_q  <= 1'b1;
                    rd_state_q <= RdIdle;
                end
                default: begin
                    arready_q  <= 1'b1;
                    rvalid_q   <= 1'b0;
                    rd_state_q <= RdIdle;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_q      <= '0;
            ovf_q       <= 1'b0;
            done_flag_q <= 1'b0;
            done_cnt_q  <= '0;
            cnt_q       <= '0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            for (int s = 0; s < int'(C_SYM_DEPTH); s++) begin
                tag_q[s] <= '0;
                for (int w = 0; w < int'(C_DATA_WORDS); w++) begin
                    slot_q[s][w] <= '0;
                end
            end
        end else begin
            if (ctrl_wr) ctrl_q <= s_axi_wdata[10:0];
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (stat_wr && s_axi_wdata[8]) begin
                ovf_q <= 1'b0;
            end
            if (done_tick) begin
                done_flag_q <= 1'b1;
            end else if (stat_wr && s_axi_wdata[9]) begin
                done_flag_q <= 1'b0;
            end
            if (dcnt_wr) begin
                done_cnt_q <= '0;
            end else if (done_tick) begin
                done_cnt_q <= done_cnt_q + 16'd1;
            end
            if (store) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_axi_wstrb[b]) slot_q[wr_ptr_q][aw_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
            if (commit) begin
                tag_q[wr_ptr_q] <= ctrl_q[1:0];
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
        end
    end

    // Stream FSM; returning to idle after each packet gives the inter-packet gap.
    always_ff @(posedge aclk) begin
        if (areset) begin
            st_q       <= StIdle;
            tvalid_q   <= 1'b0;
            word_idx_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            unique case (st_q)
                StIdle: if (cnt_q != 5'd0) begin
                    st_q     <= StSend;
                    tvalid_q <= 1'b1;
                end
                StSend: if (m_axis_tready) begin
                    if (last_beat) begin
                        word_idx_q <= '0;
                        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
                        tvalid_q   <= 1'b0;
                        st_q       <= StIdle;
                    end else begin
                        word_idx_q <= word_idx_q + IdxW'(1);
                    end
                end
                default: begin
                    tvalid_q <= 1'b0;
                    st_q     <= StIdle;
                end
            endcase
        end
    end

    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bresp    = 2'b00;
    assign s_axi_arready  = arready_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rdata    = rdata_q;
    assign s_axi_rresp    = 2'b00;
    assign m_axis_tvalid  = tvalid_q;
    assign m_axis_tdata   = slot_q[rd_ptr_q][word_idx_q];
    assign m_axis_tlast   = tvalid_q & last_beat;
    assign mod_type       = (st_q == StSend) ? tag_q[rd_ptr_q] : ctrl_q[1:0];
    assign guard_interval = ctrl_q[9:2];
    assign ifft_config    = 16'h5408;
    assign ifft_config_en = 1'b1;
    assign irq            = ctrl_q[10] & done_flag_q;

endmodule

// File: tb/tb_axi_vlctx_control_mq.sv
// Scoreboard bench for axi_vlctx_control_mq: expected beats are queued as symbols are written
// and compared when the stream handshakes.
module tb_axi_vlctx_control_mq;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = 4'hF;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [1:0]  mod_type;
    logic [7:0]  guard_interval;
    logic [15:0] ifft_config;
    logic        ifft_config_en;
    logic        done_tick = 1'b0;
    logic        irq;

    axi_vlctx_control_mq #(
        .C_DATA_WORDS(8),
        .C_SYM_DEPTH (4)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .mod_type      (mod_type),
        .guard_interval(guard_interval),
        .ifft_config   (ifft_config),
        .ifft_config_en(ifft_config_en),
        .done_tick     (done_tick),
        .irq           (irq)
    );

    always #5 aclk = ~aclk;

    typedef logic [34:0] beat_t;  // {tlast, mod_type, tdata}

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    last_w_cyc = 0;
    int    last_rise_cyc = 0;
    beat_t exp_q[$];
    beat_t exp_b;
    beat_t hold_val = '0;
    logic  stall_prev = 1'b0;
    logic  tvalid_prev = 1'b0;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (!areset) begin
            if (m_axis_tvalid && !tvalid_prev) last_rise_cyc = cyc;
            if (stall_prev && m_axis_tvalid)
                check("hold", 64'({m_axis_tlast, mod_type, m_axis_tdata}), 64'(hold_val));
            if (m_axis_tvalid && m_axis_tready) begin
                check("sb_level", 64'(exp_q.size() != 0), 64'h1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("beat", 64'({m_axis_tlast, mod_type, m_axis_tdata}), 64'(exp_b));
                end
            end
        end
        stall_prev  = m_axis_tvalid && !m_axis_tready && !areset;
        hold_val    = {m_axis_tlast, mod_type, m_axis_tdata};
        tvalid_prev = m_axis_tvalid;
    end

    task automatic push(input logic last, input logic [1:0] m, input logic [31:0] d);
        exp_q.push_back({last, m, d});
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic tick = 1'b0, input logic [3:0] strb = 4'hF);
        int n;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) check("aw_tmo", 64'(s_axi_awready), 64'h1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = d;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        done_tick     = tick;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_wready && n < 20);
        if (!s_axi_wready) check("w_tmo", 64'(s_axi_wready), 64'h1);
        last_w_cyc = cyc;
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
        done_tick    = 1'b0;
        s_axi_bready = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_bvalid && n < 20);
        check("bresp", 64'({s_axi_bvalid, s_axi_bresp}), 64'h4);
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) check("ar_tmo", 64'(s_axi_arready), 64'h1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_rvalid && n < 20);
        check("rresp", 64'({s_axi_rvalid, s_axi_rresp}), 64'h4);
        d = s_axi_rdata;
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        check(tag, 64'(v), 64'(exp));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'h0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_done();
        @(posedge aclk); #1;
        done_tick = 1'b1;
        @(posedge aclk); #1;
        done_tick = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("rst_awready", 64'(s_axi_awready), 64'h1);
        check("rst_arready", 64'(s_axi_arready), 64'h1);
        check("rst_tvalid", 64'({m_axis_tvalid, m_axis_tlast, irq}), 64'h0);
        check("rst_bv_rv", 64'({s_axi_bvalid, s_axi_rvalid}), 64'h0);
        check("rst_mod_gi", 64'({mod_type, guard_interval}), 64'h0);
        check("ifft_cfg", 64'({ifft_config_en, ifft_config}), 64'h15408);
        @(posedge aclk); #1;
        read_check("rst_status", 32'h04, 32'h4);
        read_check("rst_ctrl", 32'h00, 32'h0);
        read_check("rst_dcnt", 32'h08, 32'h0);

        // QPSK two-word symbol, latency from commit to first beat
        axi_write(32'h00, 32'h1);
        push(1'b0, 2'd1, 32'hA5A5_0001);
        push(1'b1, 2'd1, 32'hA5A5_0002);
        axi_write(32'h40, 32'hA5A5_0001);
        axi_write(32'h44, 32'hA5A5_0002);
        wait_drain();
        check("tvalid_lat", 64'(last_rise_cyc - last_w_cyc), 64'h2);
        read_check("st_outst", 32'h04, 32'h5);
        pulse_done();
        read_check("st_done", 32'h04, 32'h204);
        read_check("dcnt_1", 32'h08, 32'h1);
        axi_write(32'h04, 32'h200);
        read_check("st_w1c", 32'h04, 32'h4);
        axi_write(32'h08, 32'h0);
        read_check("dcnt_clr", 32'h08, 32'h0);

        // Fill the queue with BPSK symbols while stalled, then overflow
        m_axis_tready = 1'b0;
        axi_write(32'h00, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            push(1'b1, 2'd0, 32'(i));
            axi_write(32'h40, 32'(i));
        end
        read_check("st_full", 32'h04, 32'h23);
        axi_write(32'h40, 32'h5);
        read_check("st_ovf", 32'h04, 32'h123);
        read_check("stage_full", 32'h40, 32'h1);
        m_axis_tready = 1'b1;
        wait_drain();
        repeat (4) pulse_done();
        axi_write(32'h04, 32'h300);
        axi_write(32'h08, 32'h0);
        read_check("st_clr", 32'h04, 32'h4);

        // Modulation change between queued symbols
        m_axis_tready = 1'b0;
        axi_write(32'h00, 32'h1);
        push(1'b0, 2'd1, 32'h100);
        push(1'b1, 2'd1, 32'h101);
        axi_write(32'h40, 32'h100);
        axi_write(32'h44, 32'h101);
        axi_write(32'h00, 32'h3);
        for (int i = 0; i < 8; i++) begin
            push(i == 7, 2'd3, 32'h200 + 32'(i));
            axi_write(32'h40 + 32'(4 * i), 32'h200 + 32'(i));
        end
        @(negedge aclk);
        check("mod_tag_hold", 64'({m_axis_tvalid, mod_type}), 64'h5);
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
        wait_drain();
        repeat (2) pulse_done();
        axi_write(32'h04, 32'h300);
        axi_write(32'h08, 32'h0);
        read_check("st_clr2", 32'h04, 32'h4);

        // Commit coinciding with done_tick, irq behaviour
        axi_write(32'h00, 32'h568);
        @(negedge aclk);
        check("gi", 64'(guard_interval), 64'h5A);
        check("irq_off", 64'(irq), 64'h0);
        @(posedge aclk); #1;
        push(1'b1, 2'd0, 32'h77);
        axi_write(32'h40, 32'h77, 1'b1);
        wait_drain();
        read_check("st_simul", 32'h04, 32'h204);
        read_check("dcnt_simul", 32'h08, 32'h1);
        @(negedge aclk);
        check("irq_on", 64'(irq), 64'h1);
        @(posedge aclk); #1;
        axi_write(32'h04, 32'h200);
        @(negedge aclk);
        check("irq_clr", 64'(irq), 64'h0);
        @(posedge aclk); #1;
        read_check("st_end5", 32'h04, 32'h4);
        axi_write(32'h0C, 32'hFFFF_FFFF);
        read_check("unmapped", 32'h0C, 32'h0);

        // Reset in the middle of a four-word packet
        m_axis_tready = 1'b0;
        axi_write(32'h00, 32'h2);
        for (int i = 0; i < 4; i++) begin
            push(i == 3, 2'd2, 32'h300 + 32'(i));
            axi_write(32'h40 + 32'(4 * i), 32'h300 + 32'(i));
        end
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("tv_up", 64'(m_axis_tvalid), 64'h1);
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        check("rst_mid_tv", 64'({m_axis_tvalid, m_axis_tlast}), 64'h0);
        check("rst_mid_q", 64'(exp_q.size()), 64'h2);
        areset = 1'b0;
        m_axis_tready = 1'b0;
        exp_q.delete();
        read_check("st_after_rst", 32'h04, 32'h4);
        read_check("ctrl_after_rst", 32'h00, 32'h0);

        // Byte strobes on a staging word that does not commit
        axi_write(32'h00, 32'h3);
        axi_write(32'h40, 32'h1122_3344);
        axi_write(32'h40, 32'hAABB_CCDD, 1'b0, 4'b0101);
        read_check("wstrb", 32'h40, 32'h11BB_33DD);
        @(negedge aclk);
        check("idle_end", 64'(m_axis_tvalid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
